// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder controller. One 1-bit full-add cell is built from two
// half-adder stages and a carry flop. The controller steps that cell over
// WIDTH cycles, LSB first, to add two WIDTH-bit operands.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   start  - add request, sampled only while idle
//   a, b   - operands, captured on the accepted start edge
//   busy   - high while bits are being added
//   done   - one-cycle pulse when sum/cout hold a new result
//   sum    - (a+b) mod 2^WIDTH, held until the next result
//   cout   - carry out of bit WIDTH-1, held with sum
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Full-add cell: two half adders plus the carry flop.
    logic             ha1_s, ha1_c, bit_s, bit_c;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        ha1_s = a_sr_q[0] ^ b_sr_q[0];
        ha1_c = a_sr_q[0] & b_sr_q[0];
        bit_s = ha1_s ^ carry_q;
        bit_c = ha1_c | (ha1_s & carry_q);
        // The new bit enters at the MSB. After WIDTH shifts, bit 0 of the
        // sum has reached position 0. This form also works for WIDTH=1.
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = bit_s;
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    res_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                res_d   = res_shift;
                carry_d = bit_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Include this edge's bit and carry in the published result.
                    sum_d   = res_shift;
                    cout_d  = bit_c;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full WIDTH=8 add: pulse start, count busy cycles, wait for done
    // with a bounded loop, then check the result and that it holds.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic ec);
        int cyc, nbusy;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~a; b8 = ~b;   // post-capture changes must not matter
        cyc = 0; nbusy = 0;
        while (!done8 && cyc < 20) begin
            if (busy8) nbusy++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency8", cyc, 8);
        chk("busy_cycles8", nbusy, 8);
        chk("done_busy8", {done8, busy8}, 2'b10);
        chk("sum8", sum8, es);
        chk("cout8", cout8, ec);
        @(posedge clk); #1;
        chk("done_drop8", done8, 1'b0);
        chk("sum_hold8", {cout8, sum8}, {ec, es});
    endtask

    vec_t v8[7];
    vec_t v1[4];

    initial begin
        v8[0] = '{8'h3C, 8'h05, 8'h41, 1'b0};
        v8[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        v8[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        v8[3] = '{8'h10, 8'h20, 8'h30, 1'b0};
        v8[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
        v8[5] = '{8'h80, 8'h80, 8'h00, 1'b1};
        v8[6] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
        v1[0] = '{8'h0, 8'h0, 8'h0, 1'b0};
        v1[1] = '{8'h0, 8'h1, 8'h1, 1'b0};
        v1[2] = '{8'h1, 8'h0, 8'h1, 1'b0};
        v1[3] = '{8'h1, 8'h1, 8'h0, 1'b1};

        // Reset with start asserted and random operands
        rst = 1'b1; start8 = 1'b1; start1 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom); a1 = 1'b1; b1 = 1'b1;
        #1;
        chk("rst_now8", {busy8, done8, cout8, sum8}, 11'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_held8", {busy8, done8, cout8, sum8}, 11'h0);
        chk("rst_held1", {busy1, done1, cout1, sum1}, 4'h0);
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle8", {busy8, done8}, 2'b00);

        // Table of WIDTH=8 adds
        for (int i = 0; i < 7; i++) run8(v8[i].a, v8[i].b, v8[i].s, v8[i].c);

        // WIDTH=1 half-adder truth table
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start1 = 1'b1; a1 = v1[i].a[0]; b1 = v1[i].b[0];
            @(posedge clk); #1;
            start1 = 1'b0;
            chk("busy1", {busy1, done1}, 2'b10);
            @(posedge clk); #1;
            chk("done1", {busy1, done1}, 2'b01);
            chk("sum_cout1", {sum1, cout1}, {v1[i].s[0], v1[i].c});
            @(posedge clk); #1;
            chk("idle1", {busy1, done1}, 2'b00);
        end

        // Start during busy is ignored
        begin
            int ndone = 0;
            @(negedge clk);
            start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
            @(posedge clk);               // E0
            @(negedge clk); start8 = 1'b0;
            @(negedge clk);               // after E0+1
            @(negedge clk);               // after E0+2
            start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
            @(negedge clk); start8 = 1'b0; // sampled at E0+3 only
            for (int c = 0; c < 16; c++) begin
                @(posedge clk); #1;
                if (done8) ndone++;
            end
            chk("ignored_ndone", ndone, 1);
            chk("ignored_sum", {cout8, sum8}, 9'h030);
        end

        // Held start: done every WIDTH+2 cycles
        begin
            int first = -1, prev = -1, ndone = 0;
            @(negedge clk);
            start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
            @(posedge clk);               // E0
            for (int c = 1; c <= 30; c++) begin
                @(posedge clk); #1;
                if (done8) begin
                    ndone++;
                    if (first < 0) first = c;
                    else chk("held_period", c - prev, 10);
                    prev = c;
                end
            end
            chk("held_first", first, 8);
            chk("held_ndone", ndone, 3);
            chk("held_sum", {cout8, sum8}, 9'h002);
            @(negedge clk); start8 = 1'b0;
            repeat (12) @(posedge clk);
        end

        // Reset mid-operation: async clear, no done pulse
        begin
            int ndone = 0;
            @(negedge clk);
            start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01;
            @(posedge clk);               // E0
            @(negedge clk); start8 = 1'b0;
            repeat (3) @(posedge clk);    // E0+3
            @(posedge clk);               // E0+4
            #2 rst = 1'b1;
            #1;
            chk("midrst_async", {busy8, done8, cout8, sum8}, 11'h0);
            @(negedge clk); rst = 1'b0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (done8 || busy8) ndone++;
            end
            chk("midrst_quiet", ndone, 0);
            chk("midrst_sum", {cout8, sum8}, 9'h000);
            run8(8'h02, 8'h03, 8'h05, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
